// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the boot loader.
// master is the stream/memory side, slave is the loader itself.
interface imem_loader_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst;
   logic        done;
   logic        err;
   logic [15:0] words_loaded;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err, words_loaded
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, err, words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit LE word count, assembles LE 32-bit words from a byte
// stream and writes them to imem from address 0, holding the core in reset until done.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);
   typedef enum logic [2:0] {S_HDR0, S_HDR1, S_LOAD, S_DONE, S_ERR} state_t;

   localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

   state_t            state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [23:0]       asm_q, asm_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [ADDR_W:0]   widx_q, widx_d;
   logic [15:0]       wl_q, wl_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              in_ready_q, in_ready_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              core_rst_q, core_rst_d;

   logic              acc;
   logic [15:0]       n_full;
   logic              last_word;

   assign acc       = bus.in_valid & in_ready_q;
   assign n_full    = {bus.in_data, n_q[7:0]};
   assign last_word = (16'(widx_q) + 16'd1) == n_q;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      asm_d      = asm_q;
      bcnt_d     = bcnt_q;
      widx_d     = widx_q;
      wl_d       = wl_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      // status flags rise one cycle after the terminal state is entered
      done_d     = done_q | (state_q == S_DONE);
      core_rst_d = core_rst_q | (state_q == S_DONE);
      err_d      = err_q | (state_q == S_ERR);

      case (state_q)
         S_HDR0: if (acc) begin
            n_d[7:0] = bus.in_data;
            state_d  = S_HDR1;
         end
         S_HDR1: if (acc) begin
            n_d[15:8] = bus.in_data;
            if ({1'b0, n_full} > MAX_N) state_d = S_ERR;
            else if (n_full == 16'd0)   state_d = S_DONE;
            else                        state_d = S_LOAD;
         end
         S_LOAD: if (acc) begin
            bcnt_d = bcnt_q + 2'd1;
            asm_d  = {bus.in_data, asm_q[23:8]};
            if (bcnt_q == 2'd3) begin
               we_d    = 1'b1;
               wdata_d = {bus.in_data, asm_q};
               addr_d  = 32'(widx_q) << 2;
               widx_d  = widx_q + 1'b1;
               wl_d    = wl_q + 16'd1;
               if (last_word) state_d = S_DONE;
            end
         end
         default: ;
      endcase

      in_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_LOAD);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_HDR0;
         n_q        <= '0;
         asm_q      <= '0;
         bcnt_q     <= '0;
         widx_q     <= '0;
         wl_q       <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         in_ready_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         core_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         asm_q      <= asm_d;
         bcnt_q     <= bcnt_d;
         widx_q     <= widx_d;
         wl_q       <= wl_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         in_ready_q <= in_ready_d;
         done_q     <= done_d;
         err_q      <= err_d;
         core_rst_q <= core_rst_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.mem_we       = we_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.core_rst     = core_rst_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.words_loaded = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: stimulus queues expected writes, a negedge
// monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imem_loader_if bus();
   imem_loader #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errs   = 0;
   int checks = 0;
   logic [63:0] exp_q[$];
   bit gap_en = 1'b0;
   logic prev_we = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         chk("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_write: addr %h data %h", bus.mem_addr, bus.mem_wdata);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("write_addr", bus.mem_addr, e[63:32]);
            chk("write_data", bus.mem_wdata, e[31:0]);
         end
      end
      prev_we <= (bus.mem_we === 1'b1);
   end

   task automatic send(input logic [7:0] b);
      int n;
      if (gap_en) repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.in_ready !== 1'b1) begin
         checks++;
         errs++;
         $display("FAIL accept_timeout: in_ready %b expected 1", bus.in_ready);
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic send_word(input int idx, input logic [31:0] w);
      exp_q.push_back({32'(idx) << 2, w});
      send(w[7:0]);
      send(w[15:8]);
      send(w[23:16]);
      send(w[31:24]);
   endtask

   task automatic reset_chk();
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_core_rst", {31'd0, bus.core_rst}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_words_loaded", {16'd0, bus.words_loaded}, 32'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      reset_chk();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
   endtask

   // called right after the final accepting edge E
   task automatic expect_done(input int nwords);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("done_at_e1", {31'd0, bus.done}, 32'd0);
      chk("core_rst_at_e1", {31'd0, bus.core_rst}, 32'd0);
      chk("in_ready_at_e1", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("done_at_e2", {31'd0, bus.done}, 32'd1);
      chk("core_rst_at_e2", {31'd0, bus.core_rst}, 32'd1);
      chk("in_ready_at_e2", {31'd0, bus.in_ready}, 32'd0);
      chk("err_clear", {31'd0, bus.err}, 32'd0);
      chk("words_loaded", {16'd0, bus.words_loaded}, 32'(nwords));
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;

      // single word at full rate
      apply_reset();
      send(8'h01); send(8'h00);
      send_word(0, 32'h1234_5678);
      expect_done(1);

      // three words with random gaps, including mid-word
      apply_reset();
      gap_en = 1'b1;
      send(8'h03); send(8'h00);
      send_word(0, 32'hCAFE_BABE);
      send_word(1, 32'h0000_0001);
      send_word(2, 32'h80FF_7F00);
      gap_en = 1'b0;
      expect_done(3);

      // zero length, trailing bytes must be ignored
      apply_reset();
      send(8'h00); send(8'h00);
      expect_done(0);
      @(negedge clk);
      bus.in_data  = 8'hAA;
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("zero_extra_words", {16'd0, bus.words_loaded}, 32'd0);
      chk("zero_still_done", {31'd0, bus.done}, 32'd1);

      // overflow: N = 0x0401
      apply_reset();
      send(8'h01); send(8'h04);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ovf_in_ready_e1", {31'd0, bus.in_ready}, 32'd0);
      chk("ovf_err_e1", {31'd0, bus.err}, 32'd0);
      @(negedge clk);
      chk("ovf_err_e2", {31'd0, bus.err}, 32'd1);
      chk("ovf_done", {31'd0, bus.done}, 32'd0);
      chk("ovf_core_rst", {31'd0, bus.core_rst}, 32'd0);
      bus.in_data  = 8'h55;
      bus.in_valid = 1'b1;
      repeat (5) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ovf_in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
      chk("ovf_no_writes", {16'd0, bus.words_loaded}, 32'd0);
      chk("ovf_core_rst_hold", {31'd0, bus.core_rst}, 32'd0);

      // maximum: N = 0x0400, last write at 0xFFC
      apply_reset();
      send(8'h00); send(8'h04);
      for (int i = 0; i < 1024; i++)
         send_word(i, 32'hDEAD_0000 ^ (32'(i) * 32'h0001_0003));
      expect_done(1024);

      // reset after byte 2 of word 1 in an N=4 load
      apply_reset();
      send(8'h04); send(8'h00);
      send_word(0, 32'h1122_3344);
      send(8'hAA); send(8'hBB);
      apply_reset();
      send(8'h01); send(8'h00);
      send_word(0, 32'h0BAD_F00D);
      expect_done(1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
